tff_updown_counter: RTL

Parametrised up/down modulo counter, the multi-bit successor to the single-bit toggle flip-flop: each enabled count is a conditional toggle of the counter state. It adds load, direction, modulus, wrap/saturate mode, terminal-count pulse and a sticky overflow flag. It sits in the sequential-circuits library as the general counting primitive for timers, dividers and event counters.

---
 rtl/tff_updown_counter_if.sv | 47 ++++
 rtl/tff_updown_counter.sv | 97 +++++++++
 2 files changed

// File: rtl/tff_updown_counter_if.sv
// tff_updown_counter_if: control and status bundle for the
// up/down modulo counter.
interface tff_updown_counter_if #(
  parameter int WIDTH = 4
);

  logic             clr;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             en;
  logic             up;
  logic             sat;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;
  logic             is_max;
  logic             is_min;

  modport master (
    output clr,
    output load,
    output din,
    output en,
    output up,
    output sat,
    input  q,
    input  tc,
    input  ovf,
    input  is_max,
    input  is_min
  );

  modport slave (
    input  clr,
    input  load,
    input  din,
    input  en,
    input  up,
    input  sat,
    output q,
    output tc,
    output ovf,
    output is_max,
    output is_min
  );

endinterface

// File: rtl/tff_updown_counter.sv
// tff_updown_counter: up/down modulo counter built as a bank of
// conditional toggles, with load, clear, wrap/saturate and flags.
module tff_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  tff_updown_counter_if.slave    bus
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;

  logic [WIDTH-1:0] tgl;
  logic [WIDTH-1:0] din_cl;
  logic             at_max;
  logic             at_min;
  logic             bound;
  logic             do_clr;
  logic             do_load;
  logic             do_cnt;

  assign at_max  = (q_q == MAX);
  assign at_min  = (q_q == '0);
  assign bound   = bus.up ? at_max : at_min;
  assign din_cl  = (bus.din > MAX) ? MAX : bus.din;

  assign do_clr  = bus.clr;
  assign do_load = bus.load & ~bus.clr;
  assign do_cnt  = bus.en & ~bus.load & ~bus.clr;

  // Toggle mask: a bit flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    tgl    = '0;
    tgl[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      tgl[i] = tgl[i-1] & (bus.up ? q_q[i-1] : ~q_q[i-1]);
    end
  end

  // Next state by priority: clear, load, count, hold.
  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    unique case (1'b1)
      do_clr: begin
        q_d   = '0;
        ovf_d = 1'b0;
      end
      do_load: begin
        q_d = din_cl;
      end
      do_cnt: begin
        if (bound) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (!bus.sat) begin
            q_d = bus.up ? '0 : MAX;
          end
        end else begin
          q_d = q_q ^ tgl;
        end
      end
      default: begin
        q_d = q_q;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.tc     = tc_q;
  assign bus.ovf    = ovf_q;
  assign bus.is_max = at_max;
  assign bus.is_min = at_min;

endmodule
